dw_window_router: RTL and testbench
===================================

Name: dw_window_router

Overview:
- Parametrised successor to the depthwise data router: turns a stream of input pixel columns from the line buffer into per-tap POY x POX pixel arrays for the depthwise PE array.
- Holds a sliding 2-D window in registers and reuses overlapping columns between windows.
- Steps through all KSIZE*KSIZE kernel taps with valid/ready handshakes on both sides.
- Supports any STRIDE/KSIZE combination, right-edge zero fill at block end, and optional left zero padding.

Parameters:
- DW, 32, pixel width in bits.
- POY, 3, output rows per tap (PE array height).
- POX, 16, output columns per tap (PE array width).
- KSIZE, 3, kernel size (square); legal range 1..7.
- STRIDE, 1, convolution stride; legal range 1..KSIZE.
- Derived localparams:
  - ROWS = (POY-1)*STRIDE+KSIZE
  - WCOLS = (POX-1)*STRIDE+KSIZE
  - NEWC = POX*STRIDE
  - KEEP = WCOLS-NEWC, which must be >= 0 for legal parameters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input column valid.
- in_ready  out  1  block accepts the column this cycle.
- in_col  in  ROWS*DW  one pixel per window row; row r sits at [r*DW +: DW].
- in_blkend  in  1  qualifies the accepted column as the last column of the current row strip.
- out_valid  out  1  pe_pix holds a valid tap.
- out_ready  in  1  PE array consumes the tap.
- pe_pix  out  POY*POX*DW  pixel (y,x) sits at [(y*POX+x)*DW +: DW].
- tap_ky  out  3  kernel row of the current tap.
- tap_kx  out  3  kernel column of the current tap.
- tap_last  out  1  high with the final tap (ky=kx=KSIZE-1) of a window.
- win_last  out  1  high on every tap of the last window of a strip.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. Column counter, window registers, pe_pix, tap_ky, tap_kx, tap_last, win_last, out_valid, in_ready and busy all reset to 0.
- IDLE:
  - in_ready=1.
  - First handshake loads column 0 and moves the FSM to FILL.
- FILL:
  - in_ready=1.
  - Each handshake shifts the window left one column; the new column enters at index WCOLS-1.
  - After WCOLS columns total the FSM moves to EMIT and in_ready drops in the same cycle.
- EMIT:
  - in_ready=0. Registered output: out_valid rises the cycle after the window completes.
  - pe_pix(y,x) = win[y*STRIDE+tap_ky][x*STRIDE+tap_kx].
  - Taps advance kx-major (kx increments first, then ky) on each out_valid&&out_ready.
  - With out_ready low, pe_pix and the tap indices hold stable.
  - When the tap_last handshake completes:
    - if the window was flagged last, go to IDLE;
    - otherwise go to SLIDE and clear the column counter.
- SLIDE:
  - in_ready=1. Accepts NEWC columns with the same shift rule; the KEEP oldest-retained columns are reused.
  - After NEWC columns, go to EMIT.
- in_blkend accepted in FILL or SLIDE:
  - Flags the window as last.
  - Stops input: in_ready=0 from the next cycle.
  - The remaining column slots shift in zeros, one per cycle, then EMIT proceeds normally.
  - If blkend lands on the final column slot, no zero fill occurs.
- in_blkend accepted in IDLE: the first window is flagged last and zero-filled.
- in_blkend is ignored unless in_valid&&in_ready.
- Zero-fill cycles never assert in_ready.
- Throughput: the first window takes WCOLS+1+KSIZE^2 cycles with no backpressure; each later window takes NEWC+1+KSIZE^2 cycles.
- Arithmetic: pure data movement, no pixel arithmetic. tap_ky and tap_kx are zero-extended to 3 bits.

Optional Feature:
- Macro: DWR_ZERO_PAD_EN.
- When defined:
  - At the start of every strip (leaving IDLE), PAD=(KSIZE-1)/2 zero columns are shifted in first, one per cycle, without asserting in_ready.
  - FILL therefore consumes WCOLS-PAD real columns.
  - Zero fill at blkend is unchanged.
- When undefined: no left padding; FILL consumes WCOLS real columns.

Test Plan:
- POY=3, POX=4, KSIZE=3, STRIDE=1 (ROWS=5, WCOLS=6); feed in_col pixel(r,c)=r*16+c, out_ready=1.
  - tap(0,0): pe(y,x)=y*16+x.
  - tap(2,2): pe(1,3)=53.
  - 9 taps; tap_last on the 9th.
- Same configuration, continue 4 columns in SLIDE -> tap(0,0) pe(0,0)=4; pe(2,3)=39; in_ready high for exactly 4 handshakes.
- Same configuration, assert in_blkend with column 7 during SLIDE:
  - 2 columns accepted, then 2 zero-fill cycles with in_ready=0.
  - tap(0,2) pe(0,3)=0; win_last=1 on all taps.
  - FSM returns to IDLE after tap_last.
- STRIDE=2 (ROWS=7, WCOLS=9) -> tap(1,1) pe(2,3)=87; pe(0,0)=17.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles at tap(1,0) -> pe_pix and tap indices stable, out_valid stays 1.
  - Pulse rst_n low mid-EMIT -> all outputs 0 immediately, in_ready=1 one cycle after release.
- DWR_ZERO_PAD_EN, KSIZE=3 -> first window column 0 all zeros; tap(0,1) pe(0,0)=pixel(0,0)=0x00; FILL accepts 5 real columns.

Source files
------------

// File: rtl/dw_window_router.sv
// Depthwise window router: turns a stream of line-buffer columns into per-tap POY x POX pixel
// arrays for the depthwise PE array. The window (ROWS x WCOLS) lives in registers. Overlapping
// columns are reused between windows, and all KSIZE*KSIZE taps are stepped through in kx-major
// order.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input column handshake; in_col row r at [r*DW +: DW]
//   in_blkend            accepted column is the last of the strip; the window is zero-filled
//   out_valid/out_ready  tap handshake; pe_pix pixel (y,x) at [(y*POX+x)*DW +: DW]
//   tap_ky, tap_kx       kernel coordinates of the current tap
//   tap_last             final tap of a window
//   win_last             every tap of the last window of a strip
//   busy                 FSM not idle
//
// Optional feature macro: DWR_ZERO_PAD_EN
//   When defined, every strip starts with (KSIZE-1)/2 zero columns. While the padding is
//   pending, IDLE holds in_ready low; an in_valid in IDLE starts the strip, and the padding
//   columns are shifted in before the first real column is accepted.
module dw_window_router #(
    parameter int unsigned DW     = 32,
    parameter int unsigned POY    = 3,
    parameter int unsigned POX    = 16,
    parameter int unsigned KSIZE  = 3,
    parameter int unsigned STRIDE = 1,
    localparam int unsigned ROWS  = (POY - 1) * STRIDE + KSIZE,
    localparam int unsigned WCOLS = (POX - 1) * STRIDE + KSIZE,
    localparam int unsigned NEWC  = POX * STRIDE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DW-1:0]      in_col,
    input  logic                    in_blkend,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [POY*POX*DW-1:0]   pe_pix,
    output logic [2:0]              tap_ky,
    output logic [2:0]              tap_kx,
    output logic                    tap_last,
    output logic                    win_last,
    output logic                    busy
);

    localparam int unsigned CW   = $clog2(WCOLS + 1);
    localparam logic [2:0]  KMAX = 3'(KSIZE - 1);

`ifdef DWR_ZERO_PAD_EN
    localparam int unsigned PAD       = (KSIZE - 1) / 2;
    localparam int unsigned PW        = $clog2(PAD + 2);
    localparam bit          IdleReady = (PAD == 0);
    logic [PW-1:0] pad_q, pad_d;
`else
    localparam bit          IdleReady = 1'b1;
`endif

    typedef enum logic [1:0] {StIdle, StFill, StEmit, StSlide} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d, col_tgt;
    logic          zfill_q, zfill_d;
    logic          last_q, last_d;
    logic [DW-1:0] win_q [WCOLS][ROWS];
    logic [DW-1:0] win_d [WCOLS][ROWS];
    logic [DW-1:0] pe_q  [POY][POX];
    logic [DW-1:0] pe_d  [POY][POX];
    logic [DW-1:0] col_row [ROWS];
    logic [2:0]    ky_q, ky_d, kx_q, kx_d;
    logic          tap_last_q, tap_last_d, win_last_q, win_last_d;
    logic          out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;
    logic          in_fire, emit_done, shift_en, shift_zero, load, pad_busy_d;

    for (genvar r = 0; r < int'(ROWS); r++) begin : g_col
        assign col_row[r] = in_col[r*DW +: DW];
    end

    for (genvar y = 0; y < int'(POY); y++) begin : g_pe_y
        for (genvar x = 0; x < int'(POX); x++) begin : g_pe_x
            assign pe_pix[(y*POX+x)*DW +: DW] = pe_q[y][x];
        end
    end

    assign in_fire   = in_valid && in_ready_q;
    assign emit_done = (state_q == StEmit) && out_valid_q && out_ready && tap_last_q;
    assign col_tgt   = (state_q == StSlide) ? CW'(NEWC) : CW'(WCOLS);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            col_q       <= '0;
            zfill_q     <= 1'b0;
            last_q      <= 1'b0;
            win_q       <= '{default: '0};
            pe_q        <= '{default: '0};
            ky_q        <= '0;
            kx_q        <= '0;
            tap_last_q  <= 1'b0;
            win_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DWR_ZERO_PAD_EN
            pad_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            zfill_q     <= zfill_d;
            last_q      <= last_d;
            win_q       <= win_d;
            pe_q        <= pe_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            tap_last_q  <= tap_last_d;
            win_last_q  <= win_last_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef DWR_ZERO_PAD_EN
            pad_q       <= pad_d;
`endif
        end
    end

    // Next-state logic: column collection and window shifting
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        zfill_d    = zfill_q;
        last_d     = last_q;
        shift_en   = 1'b0;
        shift_zero = 1'b0;
`ifdef DWR_ZERO_PAD_EN
        pad_d      = pad_q;
`endif
        case (state_q)
            StIdle: begin
`ifdef DWR_ZERO_PAD_EN
                if (PAD != 0) begin
                    if (in_valid) begin
                        state_d = StFill;
                        pad_d   = PW'(PAD);
                        col_d   = '0;
                        last_d  = 1'b0;
                        zfill_d = 1'b0;
                    end
                end else
`endif
                if (in_fire) begin
                    shift_en = 1'b1;
                    col_d    = CW'(1);
                    last_d   = in_blkend;
                    zfill_d  = in_blkend;
                    state_d  = StFill;
                end
            end
            StFill, StSlide: begin
`ifdef DWR_ZERO_PAD_EN
                if (pad_q != '0) begin
                    shift_en   = 1'b1;
                    shift_zero = 1'b1;
                    pad_d      = pad_q - 1'b1;
                end else
`endif
                if (zfill_q) begin
                    shift_en   = 1'b1;
                    shift_zero = 1'b1;
                end else if (in_fire) begin
                    shift_en = 1'b1;
                    if (in_blkend) begin
                        last_d  = 1'b1;
                        zfill_d = 1'b1;
                    end
                end
                if (shift_en) col_d = col_q + 1'b1;
            end
            StEmit: begin
                if (emit_done) begin
                    if (last_q) begin
                        state_d = StIdle;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StSlide;
                        col_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Window complete; a blkend on the final slot leaves nothing to zero-fill
        if (shift_en && col_d == col_tgt) begin
            state_d = StEmit;
            col_d   = '0;
            zfill_d = 1'b0;
        end
    end

    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int c = 0; c < int'(WCOLS) - 1; c++) begin
                for (int r = 0; r < int'(ROWS); r++) win_d[c][r] = win_q[c+1][r];
            end
            for (int r = 0; r < int'(ROWS); r++) begin
                win_d[WCOLS-1][r] = shift_zero ? '0 : col_row[r];
            end
        end
    end

    // Output logic: registered tap outputs and input ready
    always_comb begin
        out_valid_d = out_valid_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        tap_last_d  = tap_last_q;
        win_last_d  = win_last_q;
        pe_d        = pe_q;
        load        = 1'b0;
        if (state_q == StEmit) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                ky_d        = '0;
                kx_d        = '0;
                load        = 1'b1;
            end else if (out_ready) begin
                if (tap_last_q) begin
                    out_valid_d = 1'b0;
                    tap_last_d  = 1'b0;
                    win_last_d  = 1'b0;
                end else begin
                    load = 1'b1;
                    if (kx_q == KMAX) begin
                        kx_d = '0;
                        ky_d = ky_q + 1'b1;
                    end else begin
                        kx_d = kx_q + 1'b1;
                    end
                end
            end
        end
        if (load) begin
            tap_last_d = (ky_d == KMAX) && (kx_d == KMAX);
            win_last_d = last_q;
            for (int y = 0; y < int'(POY); y++) begin
                for (int x = 0; x < int'(POX); x++) begin
                    for (int ky = 0; ky < int'(KSIZE); ky++) begin
                        for (int kx = 0; kx < int'(KSIZE); kx++) begin
                            if (ky_d == 3'(ky) && kx_d == 3'(kx)) begin
                                pe_d[y][x] = win_q[x*STRIDE+kx][y*STRIDE+ky];
                            end
                        end
                    end
                end
            end
        end

`ifdef DWR_ZERO_PAD_EN
        pad_busy_d = (pad_d != '0);
`else
        pad_busy_d = 1'b0;
`endif
        case (state_d)
            StIdle:          in_ready_d = IdleReady;
            StFill, StSlide: in_ready_d = !zfill_d && !pad_busy_d;
            default:         in_ready_d = 1'b0;
        endcase
        busy_d = (state_d != StIdle);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign tap_ky    = ky_q;
    assign tap_kx    = kx_q;
    assign tap_last  = tap_last_q;
    assign win_last  = win_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dw_window_router.sv
module tb_dw_window_router;

    localparam int DW    = 8;
    localparam int POY   = 3;
    localparam int POX   = 4;
    localparam int ROWS1 = 5;
    localparam int ROWS2 = 7;
    localparam int PW    = POY * POX * DW;
`ifdef DWR_ZERO_PAD_EN
    localparam bit IdleRdy = 1'b0;
`else
    localparam bit IdleRdy = 1'b1;
`endif

    logic              clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic              in_valid = 1'b0, in_blkend = 1'b0, out_ready = 1'b1;
    logic [ROWS2*DW-1:0] in_col = '0;
    logic              rdy1, rdy2, ov1, ov2, tl1, tl2, wl1, wl2, bz1, bz2;
    logic [PW-1:0]     pe1, pe2;
    logic [2:0]        ky1, ky2, kx1, kx2;

    // sel picks which instance the shared stimulus and observation signals address
    wire              in_ready  = sel ? rdy2 : rdy1;
    wire              out_valid = sel ? ov2 : ov1;
    wire [PW-1:0]     pe_pix    = sel ? pe2 : pe1;
    wire [2:0]        tap_ky    = sel ? ky2 : ky1;
    wire [2:0]        tap_kx    = sel ? kx2 : kx1;
    wire              tap_last  = sel ? tl2 : tl1;
    wire              win_last  = sel ? wl2 : wl1;
    wire              busy      = sel ? bz2 : bz1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dw_window_router #(.DW(DW), .POY(POY), .POX(POX), .KSIZE(3), .STRIDE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(rdy1),
        .in_col(in_col[ROWS1*DW-1:0]), .in_blkend(in_blkend), .out_valid(ov1),
        .out_ready(out_ready && !sel), .pe_pix(pe1), .tap_ky(ky1), .tap_kx(kx1),
        .tap_last(tl1), .win_last(wl1), .busy(bz1)
    );

    dw_window_router #(.DW(DW), .POY(POY), .POX(POX), .KSIZE(3), .STRIDE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(rdy2),
        .in_col(in_col), .in_blkend(in_blkend), .out_valid(ov2),
        .out_ready(out_ready && sel), .pe_pix(pe2), .tap_ky(ky2), .tap_kx(kx2),
        .tap_last(tl2), .win_last(wl2), .busy(bz2)
    );

    // Expected pe_pix: window column c holds pixel column off+c-padl, zero if c<padl or c>=zfrom
    function automatic logic [PW-1:0] exp_pe(input int stride, input int ky, input int kx,
                                            input int off, input int padl, input int zfrom);
        logic [PW-1:0] v;
        int c, r;
        v = '0;
        for (int y = 0; y < POY; y++) begin
            for (int x = 0; x < POX; x++) begin
                c = x * stride + kx;
                r = y * stride + ky;
                if (c >= padl && c < zfrom) v[(y*POX+x)*DW +: DW] = 8'(r * 16 + off + c - padl);
            end
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_col(input int c, input bit be, output bit ok);
        for (int r = 0; r < ROWS2; r++) in_col[r*DW +: DW] = 8'(r * 16 + c);
        in_blkend = be;
        in_valid  = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        in_blkend = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: ov=%b rdy=%b busy=%b, want 0 0 0", out_valid, in_ready, busy);
        end
        n_cmp++;
        if (pe_pix !== '0 || tap_ky !== 3'd0 || tap_kx !== 3'd0 || tap_last !== 1'b0
            || win_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: pe=%h ky=%0d kx=%0d tl=%b wl=%b, want all 0",
                     pe_pix, tap_ky, tap_kx, tap_last, win_last);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== IdleRdy) begin
            n_bad++;
            $display("FAIL reset_ready: got %b, want %b", in_ready, IdleRdy);
        end
    endtask

    task automatic test_fill();
        bit ok, all_ok;
        all_ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            send_col(c, 1'b0, ok);
            all_ok &= ok;
        end
        n_cmp++;
        if (!all_ok || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_accept: ok=%b rdy=%b ov=%b busy=%b, want 1 0 0 1",
                     all_ok, in_ready, out_valid, busy);
        end
        tick();
        for (int t = 0; t < 9; t++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || tap_ky !== 3'(t / 3) || tap_kx !== 3'(t % 3)
                || tap_last !== (t == 8) || win_last !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_tap%0d: ov=%b ky=%0d kx=%0d tl=%b wl=%b, want 1 %0d %0d %b 0",
                         t, out_valid, tap_ky, tap_kx, tap_last, win_last, t / 3, t % 3, t == 8);
            end
            n_cmp++;
            if (pe_pix !== exp_pe(1, t / 3, t % 3, 0, 0, 99)) begin
                n_bad++;
                $display("FAIL fill_pix%0d: got %h, want %h", t, pe_pix,
                         exp_pe(1, t / 3, t % 3, 0, 0, 99));
            end
            if (t == 8) begin
                n_cmp++;
                if (pe_pix[(1*POX+3)*DW +: DW] !== 8'd53) begin
                    n_bad++;
                    $display("FAIL fill_pe13: got %0d, want 53", pe_pix[(1*POX+3)*DW +: DW]);
                end
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_to_slide: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_slide_backpressure();
        bit ok, all_ok;
        all_ok = 1'b1;
        for (int c = 6; c < 10; c++) begin
            send_col(c, 1'b0, ok);
            all_ok &= ok;
        end
        n_cmp++;
        if (!all_ok || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL slide_accept: ok=%b rdy=%b, want 1 0", all_ok, in_ready);
        end
        tick();
        for (int t = 0; t < 9; t++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || tap_ky !== 3'(t / 3) || tap_kx !== 3'(t % 3)
                || pe_pix !== exp_pe(1, t / 3, t % 3, 4, 0, 99)) begin
                n_bad++;
                $display("FAIL slide_tap%0d: ov=%b ky=%0d kx=%0d pe=%h, want 1 %0d %0d %h", t,
                         out_valid, tap_ky, tap_kx, pe_pix, t / 3, t % 3,
                         exp_pe(1, t / 3, t % 3, 4, 0, 99));
            end
            if (t == 0) begin
                n_cmp++;
                if (pe_pix[0 +: DW] !== 8'd4 || pe_pix[(2*POX+3)*DW +: DW] !== 8'd39) begin
                    n_bad++;
                    $display("FAIL slide_pe: pe00=%0d pe23=%0d, want 4 39",
                             pe_pix[0 +: DW], pe_pix[(2*POX+3)*DW +: DW]);
                end
            end
            if (t == 3) begin
                out_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    n_cmp++;
                    if (out_valid !== 1'b1 || tap_ky !== 3'd1 || tap_kx !== 3'd0
                        || pe_pix !== exp_pe(1, 1, 0, 4, 0, 99)) begin
                        n_bad++;
                        $display("FAIL hold%0d: ov=%b ky=%0d kx=%0d pe=%h, want 1 1 0 %h", h,
                                 out_valid, tap_ky, tap_kx, pe_pix, exp_pe(1, 1, 0, 4, 0, 99));
                    end
                end
                out_ready = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_blkend();
        bit ok1, ok2;
        send_col(10, 1'b0, ok1);
        send_col(11, 1'b1, ok2);
        for (int z = 0; z < 3; z++) begin
            n_cmp++;
            if (!ok1 || !ok2 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL zfill%0d: ok=%b%b rdy=%b ov=%b, want 11 0 0",
                         z, ok1, ok2, in_ready, out_valid);
            end
            tick();
        end
        for (int t = 0; t < 9; t++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || tap_ky !== 3'(t / 3) || tap_kx !== 3'(t % 3)
                || win_last !== 1'b1 || tap_last !== (t == 8)
                || pe_pix !== exp_pe(1, t / 3, t % 3, 8, 0, 4)) begin
                n_bad++;
                $display("FAIL last_tap%0d: ov=%b ky=%0d kx=%0d wl=%b tl=%b pe=%h, want pe %h",
                         t, out_valid, tap_ky, tap_kx, win_last, tap_last, pe_pix,
                         exp_pe(1, t / 3, t % 3, 8, 0, 4));
            end
            if (t == 2) begin
                n_cmp++;
                if (pe_pix[3*DW +: DW] !== 8'd0) begin
                    n_bad++;
                    $display("FAIL last_pe03: got %0d, want 0", pe_pix[3*DW +: DW]);
                end
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL last_idle: busy=%b rdy=%b ov=%b, want 0 1 0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_emit();
        bit ok, all_ok;
        all_ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            send_col(c, 1'b0, ok);
            all_ok &= ok;
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (!all_ok || out_valid !== 1'b1 || tap_kx !== 3'd2) begin
            n_bad++;
            $display("FAIL pre_reset: ok=%b ov=%b kx=%0d, want 1 1 2", all_ok, out_valid, tap_kx);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || pe_pix !== '0
            || tap_ky !== 3'd0 || tap_kx !== 3'd0 || tap_last !== 1'b0 || win_last !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: ov=%b rdy=%b busy=%b pe=%h ky=%0d kx=%0d, want all 0",
                     out_valid, in_ready, busy, pe_pix, tap_ky, tap_kx);
        end
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL release_ready0: got %b, want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL release_ready1: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_stride2();
        bit ok, all_ok;
        sel    = 1'b1;
        all_ok = 1'b1;
        for (int c = 0; c < 9; c++) begin
            send_col(c, 1'b0, ok);
            all_ok &= ok;
        end
        n_cmp++;
        if (!all_ok || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL s2_accept: ok=%b rdy=%b, want 1 0", all_ok, in_ready);
        end
        tick();
        for (int t = 0; t < 9; t++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || tap_ky !== 3'(t / 3) || tap_kx !== 3'(t % 3)
                || pe_pix !== exp_pe(2, t / 3, t % 3, 0, 0, 99)) begin
                n_bad++;
                $display("FAIL s2_tap%0d: ov=%b ky=%0d kx=%0d pe=%h, want %h", t, out_valid,
                         tap_ky, tap_kx, pe_pix, exp_pe(2, t / 3, t % 3, 0, 0, 99));
            end
            if (t == 4) begin
                n_cmp++;
                if (pe_pix[(2*POX+3)*DW +: DW] !== 8'd87 || pe_pix[0 +: DW] !== 8'd17) begin
                    n_bad++;
                    $display("FAIL s2_pe: pe23=%0d pe00=%0d, want 87 17",
                             pe_pix[(2*POX+3)*DW +: DW], pe_pix[0 +: DW]);
                end
            end
            tick();
        end
        sel = 1'b0;
    endtask

    task automatic test_pad();
        bit ok, all_ok;
        all_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            send_col(c, 1'b0, ok);
            all_ok &= ok;
        end
        n_cmp++;
        if (!all_ok || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pad_accept: ok=%b rdy=%b ov=%b, want 1 0 0", all_ok, in_ready, out_valid);
        end
        tick();
        for (int t = 0; t < 9; t++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || tap_ky !== 3'(t / 3) || tap_kx !== 3'(t % 3)
                || pe_pix !== exp_pe(1, t / 3, t % 3, 0, 1, 99)) begin
                n_bad++;
                $display("FAIL pad_tap%0d: ov=%b ky=%0d kx=%0d pe=%h, want %h", t, out_valid,
                         tap_ky, tap_kx, pe_pix, exp_pe(1, t / 3, t % 3, 0, 1, 99));
            end
            if (t == 1) begin
                n_cmp++;
                if (pe_pix[0 +: DW] !== 8'h00 || pe_pix[DW +: DW] !== 8'h01) begin
                    n_bad++;
                    $display("FAIL pad_pe: pe00=%0d pe01=%0d, want 0 1",
                             pe_pix[0 +: DW], pe_pix[DW +: DW]);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
`ifdef DWR_ZERO_PAD_EN
        test_pad();
`else
        test_fill();
        test_slide_backpressure();
        test_blkend();
        test_reset_mid_emit();
        test_stride2();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
